regfile_dump: RTL and testbench

//  Readback engine for the 32-entry register file. On a start request it walks a range of

---
 rtl/regdump_pkg.sv | 14 +
 rtl/regdump_xor_acc.sv | 32 +++
 rtl/regfile_dump.sv | 226 ++++++++++++++++++++++
 tb/tb_regfile_dump.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/regdump_pkg.sv
// Shared constants for the register-file dump engine: default widths and FSM state encodings.
package regdump_pkg;

    localparam int DEF_NUM_REGS   = 32;
    localparam int DEF_ADDR_WIDTH = 5;
    localparam int DEF_DATA_WIDTH = 32;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_SEND  = 3'd2;
    localparam logic [2:0] ST_CSUM  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/regdump_xor_acc.sv
// XOR accumulator with synchronous clear and accumulate-enable; builds the dump checksum.
module regdump_xor_acc
    import regdump_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] acc
);

    logic [DATA_WIDTH-1:0] acc_r;

    // Accumulator register; clear wins over accumulate.
    always_ff @(posedge clk) begin
        if (areset) begin
            acc_r <= {DATA_WIDTH{1'b0}};
        end else if (clr) begin
            acc_r <= {DATA_WIDTH{1'b0}};
        end else if (en) begin
            acc_r <= acc_r ^ din;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/regfile_dump.sv
// Register-file readback engine: streams a wrapped address range over valid/ready.
// Optional trailing XOR checksum beat when REGDUMP_CHECKSUM_EN is defined.
module regfile_dump
    import regdump_pkg::*;
#(
    parameter int NUM_REGS   = DEF_NUM_REGS,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] first_addr,
    input  logic [ADDR_WIDTH-1:0] last_addr,
    output logic [ADDR_WIDTH-1:0] rf_rd_addr,
    input  logic [DATA_WIDTH-1:0] rf_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_last,
    output logic                  out_is_csum,
    output logic                  busy,
    output logic                  done
);

    logic [2:0]            state_r,    state_s;
    logic [ADDR_WIDTH-1:0] ptr_r,      ptr_s;
    logic [ADDR_WIDTH-1:0] last_q_r,   last_q_s;
    logic [DATA_WIDTH-1:0] out_data_r, out_data_s;
    logic [ADDR_WIDTH-1:0] out_addr_r, out_addr_s;
    logic                  out_valid_r, out_valid_s;
    logic                  out_last_r, out_last_s;
    logic                  end_r,      end_s;
    logic                  busy_r,     busy_s;
    logic                  done_r,     done_s;
    logic                  fire_s;
    logic                  load_s;
    logic [ADDR_WIDTH-1:0] ptr_inc_s;

`ifdef REGDUMP_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] csum_s;
    logic                  csum_clr_s;
    logic                  csum_en_s;
    logic                  out_is_csum_r, out_is_csum_s;

    regdump_xor_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_xor_acc (
        .clk    (clk),
        .areset (areset),
        .clr    (csum_clr_s),
        .en     (csum_en_s),
        .din    (out_data_r),
        .acc    (csum_s)
    );
`endif

    assign fire_s    = out_valid_r & out_ready;
    assign ptr_inc_s = (ptr_r == ADDR_WIDTH'(NUM_REGS - 1)) ? {ADDR_WIDTH{1'b0}}
                                                            : ptr_r + ADDR_WIDTH'(1);

    // Next-state and next-output computation; end_r marks the final data word internally.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        last_q_s    = last_q_r;
        out_data_s  = out_data_r;
        out_addr_s  = out_addr_r;
        out_valid_s = out_valid_r;
        out_last_s  = out_last_r;
        end_s       = end_r;
        done_s      = 1'b0;
        load_s      = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
        out_is_csum_s = out_is_csum_r;
        csum_clr_s    = 1'b0;
        csum_en_s     = 1'b0;
`endif
        if (abort && (state_r != ST_IDLE)) begin
            state_s     = ST_IDLE;
            out_valid_s = 1'b0;
            out_last_s  = 1'b0;
            end_s       = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            out_is_csum_s = 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        ptr_s    = first_addr;
                        last_q_s = last_addr;
                        state_s  = ST_FETCH;
`ifdef REGDUMP_CHECKSUM_EN
                        csum_clr_s = 1'b1;
`endif
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    load_s  = 1'b1;
                    state_s = ST_SEND;
                end
                ST_SEND: begin
                    if (fire_s && end_r) begin
`ifdef REGDUMP_CHECKSUM_EN
                        // Checksum must include the beat accepted on this very edge.
                        csum_en_s     = 1'b1;
                        state_s       = ST_CSUM;
                        out_data_s    = csum_s ^ out_data_r;
                        out_addr_s    = {ADDR_WIDTH{1'b0}};
                        out_last_s    = 1'b1;
                        out_is_csum_s = 1'b1;
`else
                        state_s     = ST_DONE;
                        out_valid_s = 1'b0;
                        out_last_s  = 1'b0;
                        done_s      = 1'b1;
`endif
                    end else if (fire_s) begin
`ifdef REGDUMP_CHECKSUM_EN
                        csum_en_s = 1'b1;
`endif
                        load_s  = 1'b1;
                        state_s = ST_SEND;
                    end else begin
                        state_s = ST_SEND;
                    end
                end
`ifdef REGDUMP_CHECKSUM_EN
                ST_CSUM: begin
                    if (fire_s) begin
                        state_s       = ST_DONE;
                        out_valid_s   = 1'b0;
                        out_last_s    = 1'b0;
                        out_is_csum_s = 1'b0;
                        done_s        = 1'b1;
                    end else begin
                        state_s = ST_CSUM;
                    end
                end
`endif
                ST_DONE: begin
                    state_s = ST_IDLE;
                    end_s   = 1'b0;
                end
                default: begin
                    state_s     = ST_IDLE;
                    out_valid_s = 1'b0;
                    out_last_s  = 1'b0;
                    end_s       = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
                    out_is_csum_s = 1'b0;
`endif
                end
            endcase
        end

        if (load_s) begin
            out_data_s  = rf_rd_data;
            out_addr_s  = ptr_r;
            out_valid_s = 1'b1;
            end_s       = (ptr_r == last_q_r);
`ifdef REGDUMP_CHECKSUM_EN
            out_last_s  = 1'b0;
`else
            out_last_s  = (ptr_r == last_q_r);
`endif
            ptr_s       = ptr_inc_s;
        end else begin
            ptr_s = ptr_s;
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {ADDR_WIDTH{1'b0}};
            last_q_r    <= {ADDR_WIDTH{1'b0}};
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_addr_r  <= {ADDR_WIDTH{1'b0}};
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            end_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            out_is_csum_r <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            ptr_r       <= ptr_s;
            last_q_r    <= last_q_s;
            out_data_r  <= out_data_s;
            out_addr_r  <= out_addr_s;
            out_valid_r <= out_valid_s;
            out_last_r  <= out_last_s;
            end_r       <= end_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
`ifdef REGDUMP_CHECKSUM_EN
            out_is_csum_r <= out_is_csum_s;
`endif
        end
    end

    assign rf_rd_addr = ptr_r;
    assign out_valid  = out_valid_r;
    assign out_data   = out_data_r;
    assign out_addr   = out_addr_r;
    assign out_last   = out_last_r;
    assign busy       = busy_r;
    assign done       = done_r;
`ifdef REGDUMP_CHECKSUM_EN
    assign out_is_csum = out_is_csum_r;
`else
    assign out_is_csum = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_dump.sv
// Self-checking bench for regfile_dump; expected beats come from a queue-based model of the
// address range (and XOR checksum when REGDUMP_CHECKSUM_EN is defined).
module tb_regfile_dump;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
        logic          csum;
    } beat_t;

    logic          clk = 1'b0;
    logic          areset, start, abort, out_ready;
    logic [AW-1:0] first_addr, last_addr, rf_rd_addr, out_addr;
    logic [DW-1:0] rf_rd_data, out_data;
    logic          out_valid, out_last, out_is_csum, busy, done;
    logic [DW-1:0] rf [NR];

    int    checks = 0;
    int    errors = 0;
    beat_t exp_q[$];

    always #5 clk = ~clk;

    assign rf_rd_data = rf[rf_rd_addr];

    regfile_dump dut (
        .clk         (clk),
        .areset      (areset),
        .start       (start),
        .abort       (abort),
        .first_addr  (first_addr),
        .last_addr   (last_addr),
        .rf_rd_addr  (rf_rd_addr),
        .rf_rd_data  (rf_rd_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_last    (out_last),
        .out_is_csum (out_is_csum),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: the inclusive range first..last taken modulo NR, plus optional XOR beat.
    function automatic void build_expected(input int f, input int l);
        int            n;
        logic [DW-1:0] x;
        n = ((l - f + NR) % NR) + 1;
        x = '0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            int    a;
            beat_t b;
            a      = (f + i) % NR;
            b.addr = AW'(a);
            b.data = rf[a];
            b.csum = 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == n - 1);
`endif
            x = x ^ rf[a];
            exp_q.push_back(b);
        end
`ifdef REGDUMP_CHECKSUM_EN
        begin
            beat_t c;
            c.addr = '0;
            c.data = x;
            c.last = 1'b1;
            c.csum = 1'b1;
            exp_q.push_back(c);
        end
`endif
    endfunction

    // mode 0: ready always high; 1: ready 1,0,0 repeating; 2: random ready.
    task automatic do_dump(input int f, input int l, input int mode, input bit inj_start);
        int    cyc;
        int    n_exp;
        logic  r;
        logic  hold;
        beat_t held;
        beat_t cur;
        build_expected(f, l);
        n_exp      = exp_q.size();
        first_addr = AW'(f);
        last_addr  = AW'(l);
        start      = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        first_addr = AW'($urandom);
        last_addr  = AW'($urandom);
        check("fetch_valid", out_valid, 1'b0);
        check("fetch_busy", busy, 1'b1);
        @(negedge clk);
        cyc  = 0;
        hold = 1'b0;
        held = '0;
        while (exp_q.size() > 0 && cyc < 400) begin
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            start = inj_start && (cyc == 2);
            cur   = {out_addr, out_data, out_last, out_is_csum};
            if (out_valid) begin
                if (hold) check("hold_stable", cur, held);
                if (r) begin
                    check("beat", cur, exp_q[0]);
                    void'(exp_q.pop_front());
                    hold = 1'b0;
                end else begin
                    held = cur;
                    hold = 1'b1;
                end
            end else if (hold) begin
                check("hold_valid", out_valid, 1'b1);
            end
            out_ready = r;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("drain", exp_q.size(), 0);
        if (mode == 0) check("throughput_cycles", cyc, n_exp);
        check("done_pulse", done, 1'b1);
        check("done_valid", out_valid, 1'b0);
        check("done_busy", busy, 1'b1);
        @(negedge clk);
        check("done_clear", done, 1'b0);
        check("idle_busy", busy, 1'b0);
    endtask

    initial begin
        areset = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        first_addr = '0; last_addr = '0;
        for (int i = 0; i < NR; i++) rf[i] = DW'(32'h100 + i);
        repeat (3) @(negedge clk);
        areset = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rst_busy", busy, 1'b0);
            check("rst_valid", out_valid, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_rdaddr", rf_rd_addr, 5'd0);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", busy, 1'b0);

        // Basic range, wraps, single beat, full dump.
        do_dump(3, 6, 0, 1'b0);
        do_dump(30, 1, 0, 1'b0);
        do_dump(7, 7, 0, 1'b0);
        do_dump(9, 8, 0, 1'b0);

        // Backpressure with an ignored start while busy.
        do_dump(5, 12, 1, 1'b1);

        // Abort in the second SEND cycle.
        first_addr = 5'd10; last_addr = 5'd20; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_first_valid", out_valid, 1'b1);
        check("abort_first_addr", out_addr, 5'd10);
        @(negedge clk);
        check("abort_second_addr", out_addr, 5'd11);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        @(negedge clk);
        check("abort_no_done", done, 1'b0);
        do_dump(2, 4, 0, 1'b0);

`ifdef REGDUMP_CHECKSUM_EN
        rf[4] = 32'h1; rf[5] = 32'h2; rf[6] = 32'h4;
        do_dump(4, 6, 0, 1'b0);
`endif

        // Randomized contents, ranges and ready.
        for (int k = 0; k < 8; k++) begin
            for (int i = 0; i < NR; i++) rf[i] = $urandom;
            do_dump($urandom_range(0, NR - 1), $urandom_range(0, NR - 1), 2, (k % 2 == 1));
        end

        // Reset mid-dump.
        first_addr = 5'd0; last_addr = 5'd31; start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done", done, 1'b0);
        check("mid_rst_data", out_data, 32'h0);
        check("mid_rst_addr", out_addr, 5'd0);
        check("mid_rst_last", out_last, 1'b0);
        check("mid_rst_csum", out_is_csum, 1'b0);
        check("mid_rst_rdaddr", rf_rd_addr, 5'd0);
        @(negedge clk);
        check("post_rst_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
